// File: rtl/softreg_cfg_responder_pkg.sv
// Register map, run-state encodings and STATUS layout shared by the SoftReg responder.
// STATUS packs {err, state} into the low bits of a 64-bit word.
package softreg_cfg_responder_pkg;

  localparam logic [31:0] ADDR_N_VERT           = 32'h00;
  localparam logic [31:0] ADDR_N_INEDGES        = 32'h08;
  localparam logic [31:0] ADDR_VADDR            = 32'h10;
  localparam logic [31:0] ADDR_IEADDR           = 32'h18;
  localparam logic [31:0] ADDR_WRITE_ADDR0      = 32'h20;
  localparam logic [31:0] ADDR_WRITE_ADDR1      = 32'h28;
  localparam logic [31:0] ADDR_N_ROUNDS         = 32'h30;
  localparam logic [31:0] ADDR_DONE_READ_PARAMS = 32'h38;
  localparam logic [31:0] ADDR_DONE_ALL         = 32'h40;
  localparam logic [31:0] ADDR_STATUS           = 32'h48;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int STATUS_ST_LSB  = 0;
  localparam int STATUS_ST_MSB  = 1;
  localparam int STATUS_ERR_BIT = 2;

  function automatic logic [63:0] status_word(input logic err, input logic [1:0] st);
    logic [63:0] w;
    w = '0;
    w[STATUS_ST_MSB:STATUS_ST_LSB] = st;
    w[STATUS_ERR_BIT] = err;
    return w;
  endfunction

endpackage

// File: rtl/softreg_cfg_responder.sv
// SoftReg responder: decodes host writes into PageRank config, launches the core, answers reads.
// Reads answer at latency 1 except DONE_ALL in RUN, which waits for core_done; no backpressure.
module softreg_cfg_responder
  import softreg_cfg_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              softreg_req_valid,
  input  logic              softreg_req_isWrite,
  input  logic [ADDR_W-1:0] softreg_req_addr,
  input  logic [DATA_W-1:0] softreg_req_data,
  output logic              softreg_resp_valid,
  output logic [DATA_W-1:0] softreg_resp_data,
  output logic [31:0]       n_vert,
  output logic [31:0]       n_inedges,
  output logic [63:0]       vaddr,
  output logic [63:0]       ieaddr,
  output logic [63:0]       write_addr0,
  output logic [63:0]       write_addr1,
  output logic [15:0]       n_rounds,
  output logic              start,
  output logic              busy,
  input  logic              core_done,
  input  logic [63:0]       core_result,
  output logic              err
);

  logic [1:0]  state;
  logic        pend;
  logic        is_wr;
  logic        is_rd;
  logic        cfg_open;
  logic        hit_cfg;
  logic        hit_drp;
  logic        hit_done_all;
  logic [63:0] rd_dat;

  assign is_wr        = softreg_req_valid & softreg_req_isWrite;
  assign is_rd        = softreg_req_valid & ~softreg_req_isWrite;
  assign cfg_open     = (state != ST_RUN);
  assign busy         = (state == ST_RUN);
  assign hit_drp      = (softreg_req_addr == ADDR_W'(ADDR_DONE_READ_PARAMS));
  assign hit_done_all = (softreg_req_addr == ADDR_W'(ADDR_DONE_ALL));
  assign hit_cfg      = (softreg_req_addr == ADDR_W'(ADDR_N_VERT))      ||
                        (softreg_req_addr == ADDR_W'(ADDR_N_INEDGES))   ||
                        (softreg_req_addr == ADDR_W'(ADDR_VADDR))       ||
                        (softreg_req_addr == ADDR_W'(ADDR_IEADDR))      ||
                        (softreg_req_addr == ADDR_W'(ADDR_WRITE_ADDR0)) ||
                        (softreg_req_addr == ADDR_W'(ADDR_WRITE_ADDR1)) ||
                        (softreg_req_addr == ADDR_W'(ADDR_N_ROUNDS));

  // Immediate read data; DONE_ALL while in RUN is diverted to the pending path instead.
  always_comb begin
    rd_dat = '0;
    case (softreg_req_addr)
      ADDR_W'(ADDR_N_VERT):      rd_dat = {32'b0, n_vert};
      ADDR_W'(ADDR_N_INEDGES):   rd_dat = {32'b0, n_inedges};
      ADDR_W'(ADDR_VADDR):       rd_dat = vaddr;
      ADDR_W'(ADDR_IEADDR):      rd_dat = ieaddr;
      ADDR_W'(ADDR_WRITE_ADDR0): rd_dat = write_addr0;
      ADDR_W'(ADDR_WRITE_ADDR1): rd_dat = write_addr1;
      ADDR_W'(ADDR_N_ROUNDS):    rd_dat = {48'b0, n_rounds};
      ADDR_W'(ADDR_DONE_ALL):    rd_dat = (state == ST_DONE) ? core_result : 64'b0;
      ADDR_W'(ADDR_STATUS):      rd_dat = status_word(err, state);
      default:                   rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      pend               <= 1'b0;
      start              <= 1'b0;
      err                <= 1'b0;
      softreg_resp_valid <= 1'b0;
      softreg_resp_data  <= '0;
      n_vert             <= '0;
      n_inedges          <= '0;
      vaddr              <= '0;
      ieaddr             <= '0;
      write_addr0        <= '0;
      write_addr1        <= '0;
      n_rounds           <= '0;
    end else begin
      start              <= 1'b0;
      softreg_resp_valid <= 1'b0;

      if (state == ST_RUN && core_done) state <= ST_DONE;

      if (pend && core_done) begin
        pend               <= 1'b0;
        softreg_resp_valid <= 1'b1;
        softreg_resp_data  <= DATA_W'(core_result);
      end

      if (is_wr && (hit_cfg || hit_drp) && !cfg_open) err <= 1'b1;

      if (is_wr && cfg_open) begin
        case (softreg_req_addr)
          ADDR_W'(ADDR_N_VERT):      n_vert      <= softreg_req_data[31:0];
          ADDR_W'(ADDR_N_INEDGES):   n_inedges   <= softreg_req_data[31:0];
          ADDR_W'(ADDR_VADDR):       vaddr       <= softreg_req_data[63:0];
          ADDR_W'(ADDR_IEADDR):      ieaddr      <= softreg_req_data[63:0];
          ADDR_W'(ADDR_WRITE_ADDR0): write_addr0 <= softreg_req_data[63:0];
          ADDR_W'(ADDR_WRITE_ADDR1): write_addr1 <= softreg_req_data[63:0];
          ADDR_W'(ADDR_N_ROUNDS):    n_rounds    <= softreg_req_data[15:0];
          ADDR_W'(ADDR_DONE_READ_PARAMS): begin
            start <= 1'b1;
            state <= (n_rounds == 16'd0) ? ST_DONE : ST_RUN;
          end
          default: ;
        endcase
      end

      if (is_rd) begin
        if (pend) begin
          err <= 1'b1;
        end else if (hit_done_all && state == ST_RUN) begin
          // core_done already high counts as seen this cycle: answer at latency 1.
          if (core_done) begin
            softreg_resp_valid <= 1'b1;
            softreg_resp_data  <= DATA_W'(core_result);
          end else begin
            pend <= 1'b1;
          end
        end else begin
          softreg_resp_valid <= 1'b1;
          softreg_resp_data  <= DATA_W'(rd_dat);
        end
      end
    end
  end

endmodule

// File: tb/tb_softreg_cfg_responder.sv
// Scoreboard bench for softreg_cfg_responder: expected responses are queued at request time
// and matched (data and arrival cycle) whenever softreg_resp_valid fires.
module tb_softreg_cfg_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        softreg_req_valid;
  logic        softreg_req_isWrite;
  logic [31:0] softreg_req_addr;
  logic [63:0] softreg_req_data;
  logic        softreg_resp_valid;
  logic [63:0] softreg_resp_data;
  logic [31:0] n_vert, n_inedges;
  logic [63:0] vaddr, ieaddr, write_addr0, write_addr1;
  logic [15:0] n_rounds;
  logic        start, busy, core_done, err;
  logic [63:0] core_result;

  typedef struct {
    logic [63:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   s0;

  softreg_cfg_responder #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
    .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
    .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
    .n_vert(n_vert), .n_inedges(n_inedges), .vaddr(vaddr), .ieaddr(ieaddr),
    .write_addr0(write_addr0), .write_addr1(write_addr1), .n_rounds(n_rounds),
    .start(start), .busy(busy), .core_done(core_done), .core_result(core_result),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (start) start_cnt++;
    if (softreg_resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", softreg_resp_data, 64'hDEAD_0000_0000_DEAD);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", softreg_resp_data, mon_e.dat);
        check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic req(input logic iw, input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    softreg_req_valid   = 1'b1;
    softreg_req_isWrite = iw;
    softreg_req_addr    = a;
    softreg_req_data    = d;
    @(negedge clk);
    softreg_req_valid   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    req(1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] exp);
    exp_t e;
    @(negedge clk);
    softreg_req_valid   = 1'b1;
    softreg_req_isWrite = 1'b0;
    softreg_req_addr    = a;
    softreg_req_data    = '0;
    e.dat = exp;
    e.cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    softreg_req_valid   = 1'b0;
  endtask

  task automatic finish_core(input logic [63:0] res);
    exp_t e;
    @(negedge clk);
    core_result = res;
    core_done   = 1'b1;
    e.dat = res;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
    softreg_req_addr = '0; softreg_req_data = '0;
    core_done = 1'b0; core_result = '0;
    repeat (3) @(negedge clk);
    check("rst_cfg_zero", {n_vert, n_inedges, vaddr[31:0], ieaddr[31:0], n_rounds}, 64'd0);
    check("rst_ctrl_zero", {start, busy, err, softreg_resp_valid}, 64'd0);
    check("rst_resp_data", softreg_resp_data, 64'd0);
    rst = 1'b1;

    // Configure and launch.
    wr(32'h00, 64'd10);
    wr(32'h08, 64'd56);
    wr(32'h10, 64'd0);
    wr(32'h18, 64'd160);
    wr(32'h20, 64'd640);
    wr(32'h28, 64'd768);
    wr(32'h30, 64'hFFFF_0000_0000_0002);
    check("n_vert", n_vert, 64'd10);
    check("n_inedges", n_inedges, 64'd56);
    check("ieaddr", ieaddr, 64'd160);
    check("write_addr0", write_addr0, 64'd640);
    check("write_addr1", write_addr1, 64'd768);
    check("n_rounds", n_rounds, 64'd2);
    s0 = start_cnt;
    wr(32'h38, 64'h1234);
    check("start_hi", start, 1);
    check("busy_run", busy, 1);
    @(negedge clk);
    check("start_low", start, 0);
    check("start_pulses", 64'(start_cnt - s0), 64'd1);
    rd(32'h48, 64'd1);
    rd(32'h00, 64'd10);
    drain();

    // Blocking DONE_ALL read: no response until core_done, then exactly one.
    req(1'b0, 32'h40, 64'd0);
    repeat (50) @(negedge clk);
    finish_core(64'd12345);
    drain();
    rd(32'h48, 64'd2);
    drain();
    check("busy_done", busy, 0);
    core_done = 1'b0;

    // Second run: writes and reads while a DONE_ALL read is pending.
    wr(32'h38, 64'd0);
    check("busy_rerun", busy, 1);
    req(1'b0, 32'h40, 64'd0);
    wr(32'h10, 64'd99);
    req(1'b0, 32'h48, 64'd0);
    check("vaddr_locked", vaddr, 64'd0);
    check("err_set", err, 1);
    repeat (5) @(negedge clk);
    finish_core(64'd555);
    drain();
    rd(32'h48, 64'd6);
    drain();
    core_done = 1'b0;

    // Zero rounds: start still pulses, state goes straight to DONE.
    wr(32'h30, 64'd0);
    s0 = start_cnt;
    wr(32'h38, 64'd0);
    check("start_hi_zero_rounds", start, 1);
    check("busy_zero_rounds", busy, 0);
    @(negedge clk);
    check("start_pulses_zero_rounds", 64'(start_cnt - s0), 64'd1);
    core_result = 64'd777;
    rd(32'h40, 64'd777);
    rd(32'h48, 64'd6);
    drain();

    // Asynchronous reset with a DONE_ALL read pending.
    wr(32'h30, 64'd3);
    wr(32'h38, 64'd0);
    check("busy_before_rst", busy, 1);
    req(1'b0, 32'h40, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cfg_zero", {n_vert, n_inedges, write_addr0[31:0], n_rounds}, 64'd0);
    check("arst_ctrl_zero", {start, busy, err, softreg_resp_valid}, 64'd0);
    check("arst_resp_data", softreg_resp_data, 64'd0);
    repeat (2) @(negedge clk);
    core_result = 64'd999;
    core_done = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    core_done = 1'b0;
    rd(32'h48, 64'd0);
    drain();

    // IDLE DONE_ALL, unmapped accesses.
    rd(32'h40, 64'd0);
    rd(32'h100, 64'd0);
    wr(32'h100, 64'd5);
    drain();
    check("err_unmapped", err, 0);
    rd(32'h00, 64'd0);
    drain();
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
